// File: rtl/gamma_ctrl.sv
// Gamma-cycle controller: replays latched spike times as pulse-width-encoded spikes
// over one RUN window and records the first datapath output spike. Option: GAMMA_CTRL_EARLY_TERM_EN.
module gamma_ctrl #(
   parameter int GAMMA_CYCLE_WIDTH = 16,
   parameter int PULSE_WIDTH       = 8,
   parameter int N_IN              = 2,
   localparam int T_W              = $clog2(GAMMA_CYCLE_WIDTH)
) (
   input  logic                  aclk,
   input  logic                  grst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [N_IN*T_W-1:0]   in_time,
   input  logic [N_IN-1:0]       in_mask,
   output logic                  op_rst,
   output logic [N_IN-1:0]       spike_o,
   input  logic                  dp_y,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [T_W-1:0]        res_time,
   output logic                  res_hit,
   output logic [1:0]            state_o
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
   // ready/valid never depend on the partner's signal, and neither is offered in reset.

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_RUN   = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [T_W-1:0] TCNT_LAST = T_W'(GAMMA_CYCLE_WIDTH - 1);
   localparam logic [T_W:0]   PW_EXT    = (T_W+1)'(PULSE_WIDTH);

   state_t                state_q, state_d;
   logic [T_W-1:0]        tcnt_q, tcnt_d;
   logic [N_IN*T_W-1:0]   time_q, time_d;
   logic [N_IN-1:0]       mask_q, mask_d;
   logic [T_W-1:0]        res_time_q, res_time_d;
   logic                  res_hit_q, res_hit_d;
   logic                  capture;
   logic [N_IN-1:0]       lane_on;

   assign capture = (state_q == ST_RUN) && dp_y && !res_hit_q;

   // Lane window check uses a T_W+1 bit end point so late pulses clip instead of wrapping.
   for (genvar i = 0; i < N_IN; i++) begin : g_lane
      logic [T_W-1:0] t_start;
      logic [T_W:0]   t_end;
      assign t_start    = time_q[i*T_W +: T_W];
      assign t_end      = {1'b0, t_start} + PW_EXT;
      assign lane_on[i] = mask_q[i] && (tcnt_q >= t_start) && ({1'b0, tcnt_q} < t_end);
   end

   // State register
   always_ff @(posedge aclk) begin
      if (grst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (in_valid) state_d = ST_CLEAR;
         ST_CLEAR: state_d = ST_RUN;
         ST_RUN: begin
            if (tcnt_q == TCNT_LAST) state_d = ST_DONE;
`ifdef GAMMA_CTRL_EARLY_TERM_EN
            if (capture) state_d = ST_DONE;
`endif
         end
         ST_DONE:  if (res_ready) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Output logic; reset gating keeps every strobe low while grst is held.
   always_comb begin
      in_ready  = 1'b0;
      op_rst    = 1'b0;
      res_valid = 1'b0;
      spike_o   = '0;
      if (!grst) begin
         case (state_q)
            ST_IDLE:  in_ready  = 1'b1;
            ST_CLEAR: op_rst    = 1'b1;
            ST_RUN:   spike_o   = lane_on;
            ST_DONE:  res_valid = 1'b1;
            default:  in_ready  = 1'b0;
         endcase
      end
   end

   assign res_time = res_time_q;
   assign res_hit  = res_hit_q;
   assign state_o  = state_q;

   // Datapath next-state
   always_comb begin
      tcnt_d     = tcnt_q;
      time_d     = time_q;
      mask_d     = mask_q;
      res_time_d = res_time_q;
      res_hit_d  = res_hit_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               time_d     = in_time;
               mask_d     = in_mask;
               res_time_d = '0;
               res_hit_d  = 1'b0;
               tcnt_d     = '0;
            end
         end
         ST_CLEAR: tcnt_d = '0;
         ST_RUN: begin
            tcnt_d = tcnt_q + 1'b1;
            if (capture) begin
               res_time_d = tcnt_q;
               res_hit_d  = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (grst) begin
         tcnt_q     <= '0;
         time_q     <= '0;
         mask_q     <= '0;
         res_time_q <= '0;
         res_hit_q  <= 1'b0;
      end else begin
         tcnt_q     <= tcnt_d;
         time_q     <= time_d;
         mask_q     <= mask_d;
         res_time_q <= res_time_d;
         res_hit_q  <= res_hit_d;
      end
   end

endmodule
